s4ga_cfg_streamer: RTL

// - Transmit side of the s4ga LUT-config segment stream. Holds N LUT config words and emits them continuously, SI_W bits per clock, on fab_si.
// - Drives fab_rst, which holds the fabric in reset for RST_CYC cycles before the stream starts.
// - Sits in front of the fabric: fab_rst -> io_in[1], fab_si -> io_in[5:2]. Software loads the words through a simple write port.

---
 rtl/s4ga_cfg_streamer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/s4ga_cfg_streamer.sv
// Transmit side of the s4ga LUT-config segment stream: holds N config words and
// replays them continuously, SI_W bits per clock, after a fixed-length fabric reset.
module s4ga_cfg_streamer #(
    parameter int unsigned N       = 283,
    parameter int unsigned SI_W    = 4,
    parameter int unsigned LL      = 23,
    parameter int unsigned RST_CYC = N + 2,
    localparam int unsigned N_W    = $clog2(N),
    localparam int unsigned CFG_W  = LL * SI_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             cfg_we_i,
    input  logic [N_W-1:0]   cfg_addr_i,
    input  logic [CFG_W-1:0] cfg_data_i,
    output logic             fab_rst_o,
    output logic [SI_W-1:0]  fab_si_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [N_W-1:0]   lut_n_o
);

    localparam int unsigned SEG_W = $clog2(LL);
    localparam int unsigned RC_W  = $clog2(RST_CYC);

    typedef enum logic [1:0] {StIdle, StReset, StStream} state_e;

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [N_W-1:0]   lut_q, lut_d, lut_nxt;
    logic [CFG_W-1:0] shreg_q, shreg_d;
    logic             fab_rst_q, fab_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_seg, last_lut;

    // Config store: deliberately not reset.
    logic [CFG_W-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (cfg_we_i && (32'(cfg_addr_i) < N)) begin
            mem_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign last_seg = (seg_q == SEG_W'(LL - 1));
    assign last_lut = (lut_q == N_W'(N - 1));
    assign lut_nxt  = last_lut ? '0 : lut_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            seg_q     <= '0;
            lut_q     <= '0;
            shreg_q   <= '0;
            fab_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            seg_q     <= seg_d;
            lut_q     <= lut_d;
            shreg_q   <= shreg_d;
            fab_rst_q <= fab_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Fetches read the store before a same-cycle write lands, so a write in the
    // fetch cycle is only picked up on the following frame.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        seg_d     = seg_q;
        lut_d     = lut_q;
        shreg_d   = shreg_q;
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d   = StReset;
                    rst_cnt_d = '0;
                end
            end
            StReset: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d   = StStream;
                    rst_cnt_d = '0;
                    seg_d     = '0;
                    lut_d     = '0;
                    shreg_d   = mem_q[0];
                end
            end
            StStream: begin
                if (last_seg) begin
                    seg_d   = '0;
                    lut_d   = lut_nxt;
                    shreg_d = mem_q[lut_nxt];
                    // en is only honoured at the frame boundary
                    if (last_lut && !en_i) begin
                        state_d = StIdle;
                        shreg_d = '0;
                    end
                end else begin
                    seg_d   = seg_q + 1'b1;
                    shreg_d = {shreg_q[CFG_W-SI_W-1:0], {SI_W{1'b0}}};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fab_rst_d = (state_d != StStream);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StStream) && (lut_d == N_W'(N - 1)) &&
                    (seg_d == SEG_W'(LL - 1));
    end

    assign fab_rst_o    = fab_rst_q;
    assign fab_si_o     = shreg_q[CFG_W-1 -: SI_W];
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign lut_n_o      = lut_q;

endmodule
